// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Groups the video-side signals of the VGA timing generator.
//   master : the timing generator (samples iR/iG/iB, drives everything else)
//   slave  : the consumer (colour FSM upstream / board pins downstream)
//   Signals:
//     iR, iG, iB   1-bit colour from the colour FSM
//     oR, oG, oB   blanked colour to the board pins
//     oHSync       horizontal sync, active low
//     oVSync       vertical sync, active low
//     oCol, oRow   current pixel coordinates
//     oVisible     current coordinates lie in the visible area
//     oPixelTick   one-Clock strobe, counters advance on it
//     oFrameStart  one-Clock strobe when the counters wrap to (0,0)
interface vga_timing_gen_if;
    logic       iR;
    logic       iG;
    logic       iB;
    logic       oR;
    logic       oG;
    logic       oB;
    logic       oHSync;
    logic       oVSync;
    logic [9:0] oCol;
    logic [9:0] oRow;
    logic       oVisible;
    logic       oPixelTick;
    logic       oFrameStart;

    modport master (
        input  iR, iG, iB,
        output oR, oG, oB, oHSync, oVSync, oCol, oRow,
        output oVisible, oPixelTick, oFrameStart
    );

    modport slave (
        output iR, iG, iB,
        input  oR, oG, oB, oHSync, oVSync, oCol, oRow,
        input  oVisible, oPixelTick, oFrameStart
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA 640x480@60 timing generator and blanked pixel output stage.
//   A clock divider produces the pixel strobe; a horizontal FSM walks the
//   columns of a line and a vertical FSM walks the lines of a frame.
//   Sync and colour outputs are registered on the pixel strobe, so they lag
//   the coordinates by exactly one pixel period.
//   Ports:
//     Clock  system clock (50 MHz)
//     Reset  synchronous, active high
//     vga    vga_timing_gen_if.master (colour in, syncs/colour/coords out)
//
//   Horizontal FSM
//     state | meaning
//     H_ACT | visible columns
//     H_FP  | front porch
//     H_SP  | sync pulse (oHSync low one pixel later)
//     H_BP  | back porch, last column wraps the line
//   Vertical FSM (advances on line end only)
//     state | meaning
//     V_ACT | visible rows
//     V_FP  | front porch
//     V_SP  | sync pulse (oVSync low one pixel later)
//     V_BP  | back porch, last row wraps the frame
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input logic            Clock,
    input logic            Reset,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_ACT_END = 10'(H_VISIBLE - 1);
    localparam logic [9:0] H_FP_END  = 10'(H_VISIBLE + H_FRONT - 1);
    localparam logic [9:0] H_SP_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_END = 10'(V_VISIBLE - 1);
    localparam logic [9:0] V_FP_END  = 10'(V_VISIBLE + V_FRONT - 1);
    localparam logic [9:0] V_SP_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] COL_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] ROW_VIS   = 10'(V_VISIBLE);

    typedef enum logic [1:0] {H_ACT, H_FP, H_SP, H_BP} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FP, V_SP, V_BP} v_state_t;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q;
    h_state_t         hstate_q;
    v_state_t         vstate_q;
    logic [9:0]       col_q;
    logic [9:0]       row_q;
    logic             hsync_q;
    logic             vsync_q;
    logic [2:0]       rgb_q, rgb_d;
    logic             frame_q;
    logic             visible;
    logic             line_end;
    logic             frame_end;

    assign div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    assign visible   = (col_q < COL_VIS) && (row_q < ROW_VIS);
    assign line_end  = tick_q && (col_q == H_LAST);
    assign frame_end = line_end && (row_q == V_LAST);
    assign rgb_d     = visible ? {vga.iR, vga.iG, vga.iB} : 3'b000;

    // The strobe is registered from the divider phase, so it is high in the
    // cycle after the divider reaches its last count and never during Reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= (div_q == DIV_LAST);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hstate_q <= H_ACT;
            col_q    <= '0;
        end else if (tick_q) begin
            col_q <= (col_q == H_LAST) ? 10'd0 : col_q + 10'd1;
            case (hstate_q)
                H_ACT:   if (col_q == H_ACT_END) hstate_q <= H_FP;
                H_FP:    if (col_q == H_FP_END)  hstate_q <= H_SP;
                H_SP:    if (col_q == H_SP_END)  hstate_q <= H_BP;
                H_BP:    if (col_q == H_LAST)    hstate_q <= H_ACT;
                default: hstate_q <= H_ACT;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            vstate_q <= V_ACT;
            row_q    <= '0;
        end else if (line_end) begin
            row_q <= (row_q == V_LAST) ? 10'd0 : row_q + 10'd1;
            case (vstate_q)
                V_ACT:   if (row_q == V_ACT_END) vstate_q <= V_FP;
                V_FP:    if (row_q == V_FP_END)  vstate_q <= V_SP;
                V_SP:    if (row_q == V_SP_END)  vstate_q <= V_BP;
                V_BP:    if (row_q == V_LAST)    vstate_q <= V_ACT;
                default: vstate_q <= V_ACT;
            endcase
        end
    end

    // Outputs sample the state of the pixel being left, which gives the
    // fixed one-pixel lag between coordinates and pins.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 3'b000;
            frame_q <= 1'b0;
        end else begin
            frame_q <= frame_end;
            if (tick_q) begin
                hsync_q <= (hstate_q != H_SP);
                vsync_q <= (vstate_q != V_SP);
                rgb_q   <= rgb_d;
            end
        end
    end

    assign vga.oR          = rgb_q[2];
    assign vga.oG          = rgb_q[1];
    assign vga.oB          = rgb_q[0];
    assign vga.oHSync      = hsync_q;
    assign vga.oVSync      = vsync_q;
    assign vga.oCol        = col_q;
    assign vga.oRow        = row_q;
    assign vga.oVisible    = visible;
    assign vga.oPixelTick  = tick_q;
    assign vga.oFrameStart = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

    // Shrunken timing for the per-cycle model runs.
    localparam int SHV = 8;
    localparam int SHF = 2;
    localparam int SHS = 3;
    localparam int SHB = 3;
    localparam int SVV = 6;
    localparam int SVF = 2;
    localparam int SVS = 2;
    localparam int SVB = 2;
    localparam int SHT = SHV + SHF + SHS + SHB;
    localparam int SVT = SVV + SVF + SVS + SVB;

    logic Clock = 1'b0;
    logic rst_s = 1'b1;
    logic rst_b = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #10 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    vga_timing_gen_if bus_a ();
    vga_timing_gen_if bus_c ();
    vga_timing_gen_if bus_b ();

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .CLK_DIV(2)
    ) dut_a (.Clock(Clock), .Reset(rst_s), .vga(bus_a));

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .CLK_DIV(1)
    ) dut_c (.Clock(Clock), .Reset(rst_s), .vga(bus_c));

    vga_timing_gen dut_b (.Clock(Clock), .Reset(rst_b), .vga(bus_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       vis;
        logic       tick;
        logic       fs;
        logic       hs;
        logic       vs;
        logic       pvis;
        logic       adv;
    } exp_t;

    // Expected state k clock edges after Reset was last sampled high:
    // pixel index n = (k-1)/d, coordinates follow from n, outputs from n-1.
    function automatic exp_t model(input int k, input int d);
        exp_t e;
        int   n, pc, pr;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        n    = (k == 0) ? 0 : (k - 1) / d;
        if (k > 0) begin
            e.tick = ((k - 1) % d == d - 1);
            e.adv  = (k >= d + 1) && ((k - 1) % d == 0);
        end
        e.col = 10'(n % SHT);
        e.row = 10'((n / SHT) % SVT);
        e.vis = ((n % SHT) < SHV) && (((n / SHT) % SVT) < SVV);
        e.fs  = e.adv && (n % (SHT * SVT) == 0);
        if (n > 0) begin
            pc     = (n - 1) % SHT;
            pr     = ((n - 1) / SHT) % SVT;
            e.hs   = !(pc >= SHV + SHF && pc < SHV + SHF + SHS);
            e.vs   = !(pr >= SVV + SVF && pr < SVV + SVF + SVS);
            e.pvis = (pc < SHV) && (pr < SVV);
        end
        return e;
    endfunction

    task automatic chk_all(input string who, input exp_t e, input logic [2:0] lin,
                           input logic [9:0] col, input logic [9:0] row,
                           input logic vis, input logic tick, input logic fs,
                           input logic hs, input logic vs, input logic [2:0] rgb);
        chk({who, "_col"},  32'(col),  32'(e.col));
        chk({who, "_row"},  32'(row),  32'(e.row));
        chk({who, "_vis"},  32'(vis),  32'(e.vis));
        chk({who, "_tick"}, 32'(tick), 32'(e.tick));
        chk({who, "_fs"},   32'(fs),   32'(e.fs));
        chk({who, "_hs"},   32'(hs),   32'(e.hs));
        chk({who, "_vs"},   32'(vs),   32'(e.vs));
        chk({who, "_rgb"},  32'(rgb),  32'(e.pvis ? lin : 3'b000));
    endtask

    // Measures one hsync pulse of the full-size DUT from the moment oCol hits 656.
    task automatic measure_line(input string tag);
        int w, t0, tf;
        w = 0;
        while (bus_b.oCol != 10'd656 && w < 4000) begin @(negedge Clock); w++; end
        chk({tag, "_wait656"}, 32'(w < 4000), 32'd1);
        t0 = cyc;
        w  = 0;
        while (bus_b.oHSync !== 1'b0 && w < 400) begin @(negedge Clock); w++; end
        tf = cyc;
        chk({tag, "_fall_ofs"}, 32'(tf - t0), 32'd2);
        w = 0;
        while (bus_b.oHSync === 1'b0 && w < 400) begin @(negedge Clock); w++; end
        chk({tag, "_low_len"}, 32'(cyc - tf), 32'd192);
        w = 0;
        while (bus_b.oHSync !== 1'b0 && w < 4000) begin @(negedge Clock); w++; end
        chk({tag, "_fall_spacing"}, 32'(cyc - tf), 32'd1600);
    endtask

    initial begin
        #(60000 * 20);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1);
    end

    initial begin
        int         k;
        logic [2:0] cur_in, last_a, last_c;
        exp_t       ea, ec;

        k      = 0;
        cur_in = 3'b000;
        last_a = 3'b000;
        last_c = 3'b000;
        {bus_a.iR, bus_a.iG, bus_a.iB} = cur_in;
        {bus_c.iR, bus_c.iG, bus_c.iB} = cur_in;
        {bus_b.iR, bus_b.iG, bus_b.iB} = 3'b111;

        // Small-timing DUTs (CLK_DIV 2 and 1) against the reference model.
        for (int i = 0; i < 2400; i++) begin
            @(posedge Clock);
            if (rst_s) k = 0; else k++;
            ea = model(k, 2);
            ec = model(k, 1);
            if (ea.adv) last_a = cur_in;
            if (ec.adv) last_c = cur_in;
            #5;
            chk_all("a", ea, last_a, bus_a.oCol, bus_a.oRow, bus_a.oVisible,
                    bus_a.oPixelTick, bus_a.oFrameStart, bus_a.oHSync, bus_a.oVSync,
                    {bus_a.oR, bus_a.oG, bus_a.oB});
            chk_all("c", ec, last_c, bus_c.oCol, bus_c.oRow, bus_c.oVisible,
                    bus_c.oPixelTick, bus_c.oFrameStart, bus_c.oHSync, bus_c.oVSync,
                    {bus_c.oR, bus_c.oG, bus_c.oB});
            rst_s  = (i < 4) || (i == 1300) || ($urandom_range(0, 499) == 0);
            cur_in = (i >= 600 && i < 1100) ? 3'b111 : 3'($urandom);
            {bus_a.iR, bus_a.iG, bus_a.iB} = cur_in;
            {bus_c.iR, bus_c.iG, bus_c.iB} = cur_in;
        end

        // Full-size DUT: reset behaviour and first pixel strobe.
        @(negedge Clock);
        rst_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            chk("b_rst_hs",   32'(bus_b.oHSync), 32'd1);
            chk("b_rst_vs",   32'(bus_b.oVSync), 32'd1);
            chk("b_rst_rgb",  32'({bus_b.oR, bus_b.oG, bus_b.oB}), 32'd0);
            chk("b_rst_col",  32'(bus_b.oCol), 32'd0);
            chk("b_rst_row",  32'(bus_b.oRow), 32'd0);
            chk("b_rst_tick", 32'(bus_b.oPixelTick), 32'd0);
            chk("b_rst_fs",   32'(bus_b.oFrameStart), 32'd0);
        end
        rst_b = 1'b0;
        @(negedge Clock);
        chk("b_edge1_tick", 32'(bus_b.oPixelTick), 32'd0);
        @(negedge Clock);
        chk("b_edge2_tick", 32'(bus_b.oPixelTick), 32'd1);
        chk("b_edge2_col",  32'(bus_b.oCol), 32'd0);
        @(negedge Clock);
        chk("b_edge3_col",  32'(bus_b.oCol), 32'd1);
        chk("b_edge3_tick", 32'(bus_b.oPixelTick), 32'd0);

        measure_line("b_line1");
        measure_line("b_line2");

        // Reset in the middle of a sync pulse.
        begin
            int w;
            w = 0;
            while (!(bus_b.oCol == 10'd700 && bus_b.oRow != 10'd0) && w < 4000) begin
                @(negedge Clock);
                w++;
            end
            chk("b_wait700", 32'(w < 4000), 32'd1);
            chk("b_pre_rst_hs", 32'(bus_b.oHSync), 32'd0);
        end
        rst_b = 1'b1;
        @(negedge Clock);
        rst_b = 1'b0;
        chk("b_mid_col", 32'(bus_b.oCol), 32'd0);
        chk("b_mid_row", 32'(bus_b.oRow), 32'd0);
        chk("b_mid_hs",  32'(bus_b.oHSync), 32'd1);
        chk("b_mid_rgb", 32'({bus_b.oR, bus_b.oG, bus_b.oB}), 32'd0);
        chk("b_mid_fs",  32'(bus_b.oFrameStart), 32'd0);
        measure_line("b_line3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
